// File: rtl/fp_popcnt_acc.sv
// Streams WORDS FIFO words per fingerprint vector and returns the vector's set-bit count.
// Optional macro POPCNT_PIPE_REG_EN registers the per-word popcount and adds a DRAIN state.
module fp_popcnt_acc #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4,
  parameter int CNT_W = $clog2(WIDTH*WORDS+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_q,
  output logic             fifo_rd,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cnt,
  output logic [15:0]      vec_id
);

  localparam int WC_W = $clog2(WORDS);
  localparam logic [WC_W-1:0] LAST_W = WC_W'(WORDS-1);

  localparam logic [1:0] ST_ACC   = 2'd0;
`ifdef POPCNT_PIPE_REG_EN
  localparam logic [1:0] ST_DRAIN = 2'd1;
`endif
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [15:0]      vec_id_q, vec_id_d;
  logic [CNT_W-1:0] pc;
  logic [CNT_W-1:0] add;

  // Gated by rstn so the FIFO is never popped while the block is held in reset.
  assign fifo_rd = rstn && (state_q == ST_ACC) && !fifo_empty;

  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + CNT_W'(fifo_q[i]);
  end

`ifdef POPCNT_PIPE_REG_EN
  // Pipe register holds zero on non-pop cycles, so it can be added unconditionally.
  logic [CNT_W-1:0] pc_q, pc_d;
  assign pc_d = fifo_rd ? pc : '0;
  assign add  = pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc_q <= '0;
    else       pc_q <= pc_d;
  end
`else
  assign add = fifo_rd ? pc : '0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    res_valid_d = res_valid_q;
    res_cnt_d   = res_cnt_q;
    vec_id_d    = vec_id_q;
    case (state_q)
      ST_ACC: begin
        acc_d = acc_q + add;
        if (fifo_rd) begin
          if (wcnt_q == LAST_W) begin
            wcnt_d = '0;
`ifdef POPCNT_PIPE_REG_EN
            state_d = ST_DRAIN;
`else
            state_d     = ST_HOLD;
            res_cnt_d   = acc_q + add;
            res_valid_d = 1'b1;
            acc_d       = '0;
`endif
          end else begin
            wcnt_d = wcnt_q + WC_W'(1);
          end
        end
      end
`ifdef POPCNT_PIPE_REG_EN
      ST_DRAIN: begin
        state_d     = ST_HOLD;
        res_cnt_d   = acc_q + add;
        res_valid_d = 1'b1;
        acc_d       = '0;
      end
`endif
      ST_HOLD: begin
        if (res_ready) begin
          state_d     = ST_ACC;
          res_valid_d = 1'b0;
          vec_id_d    = vec_id_q + 16'd1;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      wcnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_cnt_q   <= '0;
      vec_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      res_valid_q <= res_valid_d;
      res_cnt_q   <= res_cnt_d;
      vec_id_q    <= vec_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_cnt   = res_cnt_q;
  assign vec_id    = vec_id_q;

endmodule
